// File: rtl/multi_alarm_clock.sv
// Real-time clock with NUM_ALARMS alarms, snooze, ring timeout and 12/24 h output.
// Optional hourly chime is compiled in when HOURLY_CHIME_EN is defined.
module multi_alarm_clock #(
    parameter int NUM_ALARMS    = 4,
    parameter int TICKS_PER_SEC = 4,
    parameter int SNOOZE_MINS   = 5,
    parameter int RING_SECS     = 60,
    parameter int AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_time,
    input  logic                  set_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic                  hours_set,
    input  logic                  mins_set,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  stop,
    input  logic                  snooze,
    input  logic                  mode_24h,
    output logic [4:0]            hours_out,
    output logic [5:0]            mins_out,
    output logic [5:0]            secs_out,
    output logic                  am_pm_out,
    output logic                  speaker_out,
    output logic [AW-1:0]         ring_id
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CW = 12;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SECS);
    localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_MINS * 60);

    typedef enum logic [1:0] {MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM} mode_e;
    typedef enum logic [1:0] {R_IDLE, R_RING, R_SNOOZE} ring_e;

    function automatic logic [4:0] inc_hh(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] inc_mm(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    mode_e mode;
    always_comb begin
        mode = MODE_RUN;
        if (set_time)       mode = MODE_SET_TIME;
        else if (set_alarm) mode = MODE_SET_ALARM;
    end

    // Input edge detection: {hours_set, mins_set, stop, snooze}
    logic [3:0] edge_q, edge_d, rise;
    logic       hours_rise, mins_rise, stop_rise, snooze_rise;
    always_comb begin
        edge_d = {hours_set, mins_set, stop, snooze};
        rise   = edge_d & ~edge_q;
    end
    assign hours_rise  = rise[3];
    assign mins_rise   = rise[2];
    assign stop_rise   = rise[1];
    assign snooze_rise = rise[0];

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hh_q, hh_d;
    logic [5:0]    mm_q, mm_d, ss_q, ss_d;
    logic          sec_tick, tick_q, tick_d;

    always_comb begin
        presc_d  = presc_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        sec_tick = (mode != MODE_SET_TIME) && (presc_q == PRESC_MAX);
        tick_d   = sec_tick;
        if (mode == MODE_SET_TIME) begin
            presc_d = '0;
            ss_d    = '0;
            if (hours_rise) hh_d = inc_hh(hh_q);
            if (mins_rise)  mm_d = inc_mm(mm_q);
        end else begin
            presc_d = sec_tick ? '0 : presc_q + PW'(1);
            if (sec_tick) begin
                ss_d = inc_mm(ss_q);
                if (ss_q == 6'd59) begin
                    mm_d = inc_mm(mm_q);
                    if (mm_q == 6'd59) hh_d = inc_hh(hh_q);
                end
            end
        end
    end

    // Per-channel alarm registers and compare
    logic [4:0]            alarm_hh [NUM_ALARMS];
    logic [5:0]            alarm_mm [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match_vec;

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
        logic [4:0] a_hh_q, a_hh_d;
        logic [5:0] a_mm_q, a_mm_d;
        logic       sel;

        assign sel = (mode == MODE_SET_ALARM) && (alarm_sel == AW'(gi));

        always_comb begin
            a_hh_d = a_hh_q;
            a_mm_d = a_mm_q;
            if (sel && hours_rise) a_hh_d = inc_hh(a_hh_q);
            if (sel && mins_rise)  a_mm_d = inc_mm(a_mm_q);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                a_hh_q <= '0;
                a_mm_q <= '0;
            end else begin
                a_hh_q <= a_hh_d;
                a_mm_q <= a_mm_d;
            end
        end

        assign alarm_hh[gi]  = a_hh_q;
        assign alarm_mm[gi]  = a_mm_q;
        // tick_q with ss==0 marks the first cycle of a new minute, so this fires once
        assign match_vec[gi] = tick_q && (ss_q == 6'd0) && (mode != MODE_SET_TIME)
                               && alarm_en[gi] && (hh_q == a_hh_q) && (mm_q == a_mm_q);
    end

    logic          any_match;
    logic [AW-1:0] match_id;
    always_comb begin
        any_match = |match_vec;
        match_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match_vec[i]) match_id = AW'(i);
        end
    end

    ring_e         ring_state_q, ring_state_d;
    logic [CW-1:0] ring_cnt_q, ring_cnt_d;
    logic [AW-1:0] ring_id_q, ring_id_d;
    logic          ring_en;

    assign ring_en = alarm_en[ring_id_q];

    always_comb begin
        ring_state_d = ring_state_q;
        ring_cnt_d   = ring_cnt_q;
        ring_id_d    = ring_id_q;
        case (ring_state_q)
            R_IDLE: begin
                if (any_match) begin
                    ring_state_d = R_RING;
                    ring_cnt_d   = RING_LOAD;
                    ring_id_d    = match_id;
                end
            end
            R_RING: begin
                if (stop_rise || (ring_cnt_q == '0) || !ring_en) begin
                    ring_state_d = R_IDLE;
                end else if (snooze_rise) begin
                    ring_state_d = R_SNOOZE;
                    ring_cnt_d   = SNOOZE_LOAD;
                end else if (sec_tick) begin
                    ring_cnt_d = ring_cnt_q - CW'(1);
                end
            end
            R_SNOOZE: begin
                if (stop_rise || !ring_en) begin
                    ring_state_d = R_IDLE;
                end else if (ring_cnt_q == '0) begin
                    ring_state_d = R_RING;
                    ring_cnt_d   = RING_LOAD;
                end else if (sec_tick) begin
                    ring_cnt_d = ring_cnt_q - CW'(1);
                end
            end
            default: ring_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q       <= '0;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            hh_q         <= '0;
            mm_q         <= '0;
            ss_q         <= '0;
            ring_state_q <= R_IDLE;
            ring_cnt_q   <= '0;
            ring_id_q    <= '0;
        end else begin
            edge_q       <= edge_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            ss_q         <= ss_d;
            ring_state_q <= ring_state_d;
            ring_cnt_q   <= ring_cnt_d;
            ring_id_q    <= ring_id_d;
        end
    end

`ifdef HOURLY_CHIME_EN
    localparam int CHW = $clog2(TICKS_PER_SEC + 1);
    localparam logic [CHW-1:0] CHIME_LOAD = CHW'(TICKS_PER_SEC);

    logic [CHW-1:0] chime_cnt_q, chime_cnt_d;

    // A ringing alarm always takes over the speaker from the chime
    always_comb begin
        chime_cnt_d = chime_cnt_q;
        if ((ring_state_q != R_IDLE) || any_match) begin
            chime_cnt_d = '0;
        end else if (tick_q && (ss_q == 6'd0) && (mm_q == 6'd0) && (mode == MODE_RUN)) begin
            chime_cnt_d = CHIME_LOAD;
        end else if (chime_cnt_q != '0) begin
            chime_cnt_d = chime_cnt_q - CHW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chime_cnt_q <= '0;
        else          chime_cnt_q <= chime_cnt_d;
    end

    assign speaker_out = (ring_state_q == R_RING) || (chime_cnt_q != '0);
`else
    assign speaker_out = (ring_state_q == R_RING);
`endif

    assign ring_id  = ring_id_q;
    assign secs_out = ss_q;

    // alarm_sel beyond the last channel falls back to showing the time
    logic sel_valid;
    if (NUM_ALARMS == (1 << AW)) begin : g_sel_full
        assign sel_valid = 1'b1;
    end else begin : g_sel_part
        assign sel_valid = (alarm_sel < AW'(NUM_ALARMS));
    end

    logic [4:0] disp_hh;
    always_comb begin
        disp_hh  = hh_q;
        mins_out = mm_q;
        if ((mode == MODE_SET_ALARM) && sel_valid) begin
            disp_hh  = alarm_hh[alarm_sel];
            mins_out = alarm_mm[alarm_sel];
        end
        hours_out = disp_hh;
        am_pm_out = 1'b0;
        if (!mode_24h) begin
            if (disp_hh == 5'd0) begin
                hours_out = 5'd12;
            end else if (disp_hh == 5'd12) begin
                am_pm_out = 1'b1;
            end else if (disp_hh > 5'd12) begin
                hours_out = disp_hh - 5'd12;
                am_pm_out = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed testbench for multi_alarm_clock (TICKS_PER_SEC=4, SNOOZE_MINS=1, RING_SECS=3).
module tb_multi_alarm_clock;

    localparam int NA = 4;
    localparam int AWB = 2;
`ifdef HOURLY_CHIME_EN
    localparam int CHIME_EXP = 4;
`else
    localparam int CHIME_EXP = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           set_time = 1'b0;
    logic           set_alarm = 1'b0;
    logic [AWB-1:0] alarm_sel = '0;
    logic           hours_set = 1'b0;
    logic           mins_set = 1'b0;
    logic [NA-1:0]  alarm_en = '0;
    logic           stop = 1'b0;
    logic           snooze = 1'b0;
    logic           mode_24h = 1'b1;
    logic [4:0]     hours_out;
    logic [5:0]     mins_out;
    logic [5:0]     secs_out;
    logic           am_pm_out;
    logic           speaker_out;
    logic [AWB-1:0] ring_id;

    int vec_cnt = 0;
    int err_cnt = 0;

    multi_alarm_clock #(
        .NUM_ALARMS(NA),
        .TICKS_PER_SEC(4),
        .SNOOZE_MINS(1),
        .RING_SECS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .set_time(set_time),
        .set_alarm(set_alarm),
        .alarm_sel(alarm_sel),
        .hours_set(hours_set),
        .mins_set(mins_set),
        .alarm_en(alarm_en),
        .stop(stop),
        .snooze(snooze),
        .mode_24h(mode_24h),
        .hours_out(hours_out),
        .mins_out(mins_out),
        .secs_out(secs_out),
        .am_pm_out(am_pm_out),
        .speaker_out(speaker_out),
        .ring_id(ring_id)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0; set_time = 1'b0; set_alarm = 1'b0; alarm_sel = '0;
        hours_set = 1'b0; mins_set = 1'b0; alarm_en = '0; stop = 1'b0;
        snooze = 1'b0; mode_24h = 1'b1;
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    endtask

    // which: 0 = hours_set, 1 = mins_set
    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (which == 0) hours_set = 1'b1; else mins_set = 1'b1;
            @(posedge clk); #1;
            hours_set = 1'b0; mins_set = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Returns at the first falling edge where the 24 h time equals h:m:s
    task automatic wait_time(input int h, input int m, input int s, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (hours_out == 5'(h) && mins_out == 6'(m) && secs_out == 6'(s)) break;
        end
        if (i == bound) begin
            vec_cnt++; err_cnt++;
            $display("FAIL wait_time: %0d:%0d:%0d not reached, got %0d:%0d:%0d", h, m, s,
                     hours_out, mins_out, secs_out);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mode_24h = 1'b0;
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd12) begin err_cnt++; $display("FAIL reset_hours12: got %0d expected 12", hours_out); end
        vec_cnt++; if (mins_out !== 6'd0) begin err_cnt++; $display("FAIL reset_mins: got %0d expected 0", mins_out); end
        vec_cnt++; if (secs_out !== 6'd0) begin err_cnt++; $display("FAIL reset_secs: got %0d expected 0", secs_out); end
        vec_cnt++; if (am_pm_out !== 1'b0) begin err_cnt++; $display("FAIL reset_ampm: got %0d expected 0", am_pm_out); end
        vec_cnt++; if (speaker_out !== 1'b0) begin err_cnt++; $display("FAIL reset_speaker: got %0d expected 0", speaker_out); end
        vec_cnt++; if (ring_id !== 2'd0) begin err_cnt++; $display("FAIL reset_ring_id: got %0d expected 0", ring_id); end
        mode_24h = 1'b1; #1;
        vec_cnt++; if (hours_out !== 5'd0) begin err_cnt++; $display("FAIL reset_hours24: got %0d expected 0", hours_out); end
        $display("test_reset done");
    endtask

    task automatic test_set_time();
        do_reset();
        @(posedge clk); #1 set_time = 1'b1;
        pulse(0, 23); pulse(1, 59);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd23 || mins_out !== 6'd59) begin err_cnt++; $display("FAIL set_23_59: got %0d:%0d expected 23:59", hours_out, mins_out); end
        pulse(1, 1);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd23 || mins_out !== 6'd0) begin err_cnt++; $display("FAIL mins_wrap_no_carry: got %0d:%0d expected 23:0", hours_out, mins_out); end
        pulse(0, 1);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd0) begin err_cnt++; $display("FAIL hours_wrap: got %0d expected 0", hours_out); end
        @(posedge clk); #1 mins_set = 1'b1;
        repeat (6) @(posedge clk);
        #1 mins_set = 1'b0;
        @(negedge clk);
        vec_cnt++; if (mins_out !== 6'd1) begin err_cnt++; $display("FAIL hold_one_step: got %0d expected 1", mins_out); end
        repeat (20) @(negedge clk);
        vec_cnt++; if (secs_out !== 6'd0) begin err_cnt++; $display("FAIL secs_held: got %0d expected 0", secs_out); end
        set_alarm = 1'b1; alarm_sel = 2'd0;
        pulse(1, 1);
        @(negedge clk);
        vec_cnt++; if (mins_out !== 6'd2) begin err_cnt++; $display("FAIL set_time_priority: got %0d expected 2", mins_out); end
        @(posedge clk); #1 set_time = 1'b0;
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd0 || mins_out !== 6'd0) begin err_cnt++; $display("FAIL alarm0_untouched: got %0d:%0d expected 0:0", hours_out, mins_out); end
        set_alarm = 1'b0;
        $display("test_set_time done");
    endtask

    task automatic test_rollover();
        do_reset();
        @(posedge clk); #1 set_time = 1'b1;
        pulse(0, 23); pulse(1, 59);
        set_time = 1'b0;
        wait_time(23, 59, 58, 300);
        repeat (8) @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd0 || mins_out !== 6'd0 || secs_out !== 6'd0) begin err_cnt++; $display("FAIL rollover_midnight: got %0d:%0d:%0d expected 0:0:0", hours_out, mins_out, secs_out); end
        repeat (4) @(negedge clk);
        vec_cnt++; if (secs_out !== 6'd1) begin err_cnt++; $display("FAIL rollover_secs1: got %0d expected 1", secs_out); end
        mode_24h = 1'b0; #1;
        vec_cnt++; if (hours_out !== 5'd12 || am_pm_out !== 1'b0) begin err_cnt++; $display("FAIL midnight_12am: got %0d pm=%0d expected 12 pm=0", hours_out, am_pm_out); end
        @(posedge clk); #1 set_time = 1'b1;
        pulse(0, 12);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd12 || am_pm_out !== 1'b1) begin err_cnt++; $display("FAIL noon_12pm: got %0d pm=%0d expected 12 pm=1", hours_out, am_pm_out); end
        pulse(0, 1);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd1 || am_pm_out !== 1'b1) begin err_cnt++; $display("FAIL h13_1pm: got %0d pm=%0d expected 1 pm=1", hours_out, am_pm_out); end
        mode_24h = 1'b1; #1;
        vec_cnt++; if (hours_out !== 5'd13 || am_pm_out !== 1'b0) begin err_cnt++; $display("FAIL h13_24h: got %0d pm=%0d expected 13 pm=0", hours_out, am_pm_out); end
        @(posedge clk); #1 set_time = 1'b0;
        $display("test_rollover done");
    endtask

    task automatic test_alarm_snooze();
        int low;
        do_reset();
        @(posedge clk); #1 set_alarm = 1'b1; alarm_sel = 2'd2;
        pulse(0, 7); pulse(1, 30);
        @(negedge clk);
        vec_cnt++; if (hours_out !== 5'd7 || mins_out !== 6'd30) begin err_cnt++; $display("FAIL alarm2_display: got %0d:%0d expected 7:30", hours_out, mins_out); end
        alarm_sel = 2'd1;
        pulse(0, 7); pulse(1, 30);
        set_alarm = 1'b0; alarm_en = 4'b0110;
        set_time = 1'b1;
        pulse(0, 7); pulse(1, 29);
        set_time = 1'b0;
        wait_time(7, 30, 0, 400);
        vec_cnt++; if (speaker_out !== 1'b0) begin err_cnt++; $display("FAIL ring_early: got %0d expected 0", speaker_out); end
        @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b1) begin err_cnt++; $display("FAIL ring_start: got %0d expected 1", speaker_out); end
        vec_cnt++; if (ring_id !== 2'd1) begin err_cnt++; $display("FAIL ring_lowest_id: got %0d expected 1", ring_id); end
        // Snooze edge lands three cycles before the next second tick
        @(posedge clk); @(posedge clk); @(posedge clk); #1 snooze = 1'b1;
        @(negedge clk);
        low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            snooze = 1'b0;
            if (speaker_out) break;
            low++;
        end
        vec_cnt++; if (low != 240) begin err_cnt++; $display("FAIL snooze_len: got %0d clks expected 240", low); end
        vec_cnt++; if (ring_id !== 2'd1) begin err_cnt++; $display("FAIL snooze_ring_id: got %0d expected 1", ring_id); end
        @(posedge clk); #1 stop = 1'b1;
        @(negedge clk); @(negedge clk);
        stop = 1'b0;
        vec_cnt++; if (speaker_out !== 1'b0) begin err_cnt++; $display("FAIL stop_silences: got %0d expected 0", speaker_out); end
        $display("test_alarm_snooze done");
    endtask

    task automatic test_stop_wins();
        int hi;
        do_reset();
        @(posedge clk); #1 set_alarm = 1'b1; alarm_sel = 2'd0;
        pulse(1, 1);
        set_alarm = 1'b0; alarm_en = 4'b0001;
        wait_time(0, 1, 0, 400);
        @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b1 || ring_id !== 2'd0) begin err_cnt++; $display("FAIL ring0_start: got spk=%0d id=%0d expected spk=1 id=0", speaker_out, ring_id); end
        @(posedge clk); #1 stop = 1'b1; snooze = 1'b1;
        @(posedge clk); #1 stop = 1'b0; snooze = 1'b0;
        @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b0) begin err_cnt++; $display("FAIL stop_snooze_same: got %0d expected 0", speaker_out); end
        hi = 0;
        repeat (260) begin
            @(negedge clk);
            if (speaker_out) hi++;
        end
        vec_cnt++; if (hi != 0) begin err_cnt++; $display("FAIL stop_wins_idle: got %0d high clks expected 0", hi); end
        $display("test_stop_wins done");
    endtask

    task automatic test_timeout_enable();
        int hi;
        do_reset();
        @(posedge clk); #1 set_alarm = 1'b1; alarm_sel = 2'd3;
        pulse(1, 1);
        alarm_sel = 2'd2; pulse(1, 2);
        alarm_sel = 2'd1; pulse(1, 3);
        set_alarm = 1'b0; alarm_en = 4'b1110;
        wait_time(0, 1, 0, 400);
        @(negedge clk);
        vec_cnt++; if (ring_id !== 2'd3) begin err_cnt++; $display("FAIL ring3_id: got %0d expected 3", ring_id); end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!speaker_out) break;
            hi++;
            @(negedge clk);
        end
        vec_cnt++; if (hi != 12) begin err_cnt++; $display("FAIL ring_timeout: got %0d clks expected 12", hi); end
        wait_time(0, 2, 0, 400);
        @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b1 || ring_id !== 2'd2) begin err_cnt++; $display("FAIL ring2_start: got spk=%0d id=%0d expected spk=1 id=2", speaker_out, ring_id); end
        @(posedge clk); #1 alarm_en[2] = 1'b0;
        @(negedge clk); @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b0) begin err_cnt++; $display("FAIL en_deassert: got %0d expected 0", speaker_out); end
        wait_time(0, 3, 0, 400);
        @(negedge clk);
        vec_cnt++; if (speaker_out !== 1'b1 || ring_id !== 2'd1) begin err_cnt++; $display("FAIL ring1_start: got spk=%0d id=%0d expected spk=1 id=1", speaker_out, ring_id); end
        #2 reset_n = 1'b0;
        #1;
        vec_cnt++; if (speaker_out !== 1'b0 || ring_id !== 2'd0) begin err_cnt++; $display("FAIL async_reset: got spk=%0d id=%0d expected spk=0 id=0", speaker_out, ring_id); end
        @(posedge clk); #1 reset_n = 1'b1;
        $display("test_timeout_enable done");
    endtask

    task automatic test_chime();
        int hi;
        do_reset();
        @(posedge clk); #1 set_time = 1'b1;
        pulse(1, 59);
        set_time = 1'b0;
        wait_time(0, 59, 58, 400);
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (speaker_out) hi++;
        end
        vec_cnt++; if (hi != CHIME_EXP) begin err_cnt++; $display("FAIL hour_chime: got %0d clks expected %0d", hi, CHIME_EXP); end
        vec_cnt++; if (hours_out !== 5'd1 || mins_out !== 6'd0 || secs_out !== 6'd2) begin err_cnt++; $display("FAIL chime_time: got %0d:%0d:%0d expected 1:0:2", hours_out, mins_out, secs_out); end
        $display("test_chime done");
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_rollover();
        test_alarm_snooze();
        test_stop_wins();
        test_timeout_enable();
        test_chime();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
